// File: rtl/fx1_result_if.sv
`default_nettype none
// ============================================================================
// Module   : fx1_result_if
// Brief    : Issue, forwarding and writeback signals of the FX1 result pipe.
// Revision : 1.0  initial release
// ============================================================================
interface fx1_result_if;
    logic         in_valid;
    logic [0:6]   in_rt_addr;
    logic [0:127] in_result;
    logic         flush;
    logic [0:6]   src_addr_a;
    logic [0:6]   src_addr_b;
    logic [0:6]   src_addr_c;
    logic         fwd_hit_a;
    logic         fwd_hit_b;
    logic         fwd_hit_c;
    logic [0:127] fwd_data_a;
    logic [0:127] fwd_data_b;
    logic [0:127] fwd_data_c;
    logic         fwd_pending_a;
    logic         fwd_pending_b;
    logic         fwd_pending_c;
    logic         wb_valid;
    logic [0:6]   wb_rt_addr;
    logic [0:127] wb_data;

    modport master (
        output in_valid, in_rt_addr, in_result, flush,
        output src_addr_a, src_addr_b, src_addr_c,
        input  fwd_hit_a, fwd_hit_b, fwd_hit_c,
        input  fwd_data_a, fwd_data_b, fwd_data_c,
        input  fwd_pending_a, fwd_pending_b, fwd_pending_c,
        input  wb_valid, wb_rt_addr, wb_data
    );

    modport slave (
        input  in_valid, in_rt_addr, in_result, flush,
        input  src_addr_a, src_addr_b, src_addr_c,
        output fwd_hit_a, fwd_hit_b, fwd_hit_c,
        output fwd_data_a, fwd_data_b, fwd_data_c,
        output fwd_pending_a, fwd_pending_b, fwd_pending_c,
        output wb_valid, wb_rt_addr, wb_data
    );
endinterface
`default_nettype wire

// File: rtl/fx1_result_pipe.sv
`default_nettype none
// ============================================================================
// Module   : fx1_result_pipe
// Brief    : FX1 result staging pipe with 3-port operand forwarding lookup.
// Revision : 1.0  initial release
// ============================================================================
module fx1_result_pipe #(
    parameter int DEPTH       = 7,
    parameter int FWD_MIN     = 2,
    parameter int FLUSH_DEPTH = 3
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    fx1_result_if.slave bus
);

    logic         r_valid [1:DEPTH];
    logic [0:6]   r_rt    [1:DEPTH];
    logic [0:127] r_data  [1:DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 1; k <= DEPTH; k++) begin
                r_valid[k] <= 1'b0;
                r_rt[k]    <= '0;
                r_data[k]  <= '0;
            end
        end else begin
            r_valid[1] <= bus.in_valid & ~bus.flush;
            r_rt[1]    <= bus.flush ? '0 : bus.in_rt_addr;
            r_data[1]  <= bus.flush ? '0 : bus.in_result;
            for (int k = 2; k <= DEPTH; k++) begin
                // Killed stages are zeroed so dead results never leak onto a bus
                if (bus.flush && (k <= FLUSH_DEPTH)) begin
                    r_valid[k] <= 1'b0;
                    r_rt[k]    <= '0;
                    r_data[k]  <= '0;
                end else begin
                    r_valid[k] <= r_valid[k-1];
                    r_rt[k]    <= r_rt[k-1];
                    r_data[k]  <= r_data[k-1];
                end
            end
        end
    end

    assign bus.wb_valid   = r_valid[DEPTH];
    assign bus.wb_rt_addr = r_rt[DEPTH];
    assign bus.wb_data    = r_data[DEPTH];

    logic [0:6]   w_src      [3];
    logic [2:0]   w_hit;
    logic [2:0]   w_pending;
    logic [0:127] w_fwd_data [3];

    assign w_src[0] = bus.src_addr_a;
    assign w_src[1] = bus.src_addr_b;
    assign w_src[2] = bus.src_addr_c;

    for (genvar s = 0; s < 3; s++) begin : g_src
        logic         w_match;
        logic         w_fwd_ok;
        logic [0:127] w_sel;

        // Scan oldest to youngest so the youngest match overrides; a stale older
        // copy must never be forwarded past a younger in-flight producer.
        always_comb begin
            w_match  = 1'b0;
            w_fwd_ok = 1'b0;
            w_sel    = '0;
            for (int k = DEPTH; k >= 1; k--) begin
                if (r_valid[k] && (r_rt[k] == w_src[s])) begin
                    w_match  = 1'b1;
                    w_fwd_ok = (k >= FWD_MIN);
                    w_sel    = r_data[k];
                end
            end
        end

        assign w_hit[s]      = w_match & w_fwd_ok;
        assign w_pending[s]  = w_match & ~w_fwd_ok;
        assign w_fwd_data[s] = (w_match & w_fwd_ok) ? w_sel : '0;
    end

    assign bus.fwd_hit_a     = w_hit[0];
    assign bus.fwd_hit_b     = w_hit[1];
    assign bus.fwd_hit_c     = w_hit[2];
    assign bus.fwd_pending_a = w_pending[0];
    assign bus.fwd_pending_b = w_pending[1];
    assign bus.fwd_pending_c = w_pending[2];
    assign bus.fwd_data_a    = w_fwd_data[0];
    assign bus.fwd_data_b    = w_fwd_data[1];
    assign bus.fwd_data_c    = w_fwd_data[2];

endmodule
`default_nettype wire

// File: tb/tb_fx1_result_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_fx1_result_pipe
// Brief    : Scoreboard bench for fx1_result_pipe (default and shallow builds).
// Revision : 1.0  initial release
// ============================================================================
module tb_fx1_result_pipe;

    localparam int c_DEPTH = 7;
    localparam int c_FWD   = 2;
    localparam int c_FLUSH = 3;

    typedef struct {
        int           issue;
        int           due;
        logic [0:6]   rt;
        logic [0:127] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   edge_cnt = 0;
    exp_t sbq[$];

    fx1_result_if bus ();
    fx1_result_if bus2 ();

    fx1_result_pipe #(.DEPTH(c_DEPTH), .FWD_MIN(c_FWD), .FLUSH_DEPTH(c_FLUSH)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    fx1_result_pipe #(.DEPTH(4), .FWD_MIN(1), .FLUSH_DEPTH(2)) u_dut_shallow (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2.slave)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s act=%h exp=%h t=%0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one issue slot for the coming edge; the scoreboard tracks what must retire.
    task automatic drive(input logic v, input logic [0:6] rt, input logic [0:127] d, input logic fl);
        int   f;
        exp_t e;
        f = edge_cnt + 1;
        bus.in_valid   = v;
        bus.in_rt_addr = rt;
        bus.in_result  = d;
        bus.flush      = fl;
        if (fl) begin
            for (int j = sbq.size() - 1; j >= 0; j--)
                if (sbq[j].issue >= f - c_FLUSH + 1) sbq.delete(j);
        end else if (v) begin
            e.issue = f;
            e.due   = f + c_DEPTH - 1;
            e.rt    = rt;
            e.data  = d;
            sbq.push_back(e);
        end
    endtask

    task automatic idle();
        drive(1'b0, 7'd0, 128'd0, 1'b0);
    endtask

    // Writeback monitor: every cycle either the expected retirement or silence.
    always begin
        @(posedge clk);
        edge_cnt++;
        #2;
        if (sbq.size() > 0 && sbq[0].due == edge_cnt) begin
            check_eq("wb_valid", {127'd0, bus.wb_valid}, 128'd1);
            check_eq("wb_rt", {121'd0, bus.wb_rt_addr}, {121'd0, sbq[0].rt});
            check_eq("wb_data", bus.wb_data, sbq[0].data);
            void'(sbq.pop_front());
        end else begin
            check_eq("wb_idle", {127'd0, bus.wb_valid}, 128'd0);
        end
    end

    initial begin
        logic [0:127] d_a;
        logic [0:127] d_b;
        logic [0:127] d9;
        logic [0:127] dv [5];

        bus.in_valid = 1'b0; bus.in_rt_addr = '0; bus.in_result = '0; bus.flush = 1'b0;
        bus.src_addr_a = '0; bus.src_addr_b = '0; bus.src_addr_c = '0;
        bus2.in_valid = 1'b0; bus2.in_rt_addr = '0; bus2.in_result = '0; bus2.flush = 1'b0;
        bus2.src_addr_a = '0; bus2.src_addr_b = '0; bus2.src_addr_c = '0;

        // Asynchronous reset values before any clock edge
        #1;
        check_eq("rst_wb_valid", {127'd0, bus.wb_valid}, 128'd0);
        check_eq("rst_wb_rt", {121'd0, bus.wb_rt_addr}, 128'd0);
        check_eq("rst_wb_data", bus.wb_data, 128'd0);
        check_eq("rst_fwd_flags", {122'd0, bus.fwd_hit_a, bus.fwd_hit_b, bus.fwd_hit_c,
                 bus.fwd_pending_a, bus.fwd_pending_b, bus.fwd_pending_c}, 128'd0);
        tick(); tick();
        rst_n = 1'b1;

        // Single issue
        drive(1'b1, 7'd5, 128'h0123456789ABCDEF0123456789ABCDEF, 1'b0);
        tick();
        idle();
        repeat (9) tick();

        // Forward / pending window
        d9 = {$urandom(), $urandom(), $urandom(), $urandom()};
        bus.src_addr_a = 7'd9;
        drive(1'b1, 7'd9, d9, 1'b0);
        tick();
        idle();
        check_eq("fwd_pend_a", {127'd0, bus.fwd_pending_a}, 128'd1);
        check_eq("fwd_nohit_a", {127'd0, bus.fwd_hit_a}, 128'd0);
        check_eq("fwd_zero_a", bus.fwd_data_a, 128'd0);
        for (int i = 1; i <= 6; i++) begin
            tick();
            check_eq("fwd_hit_a", {127'd0, bus.fwd_hit_a}, 128'd1);
            check_eq("fwd_nopend_a", {127'd0, bus.fwd_pending_a}, 128'd0);
            check_eq("fwd_data_a", bus.fwd_data_a, d9);
        end
        tick();
        check_eq("fwd_gone_a", {126'd0, bus.fwd_hit_a, bus.fwd_pending_a}, 128'd0);
        repeat (2) tick();

        // Youngest match wins over an older stale copy
        d_a = {$urandom(), $urandom(), $urandom(), $urandom()};
        d_b = {$urandom(), $urandom(), $urandom(), $urandom()};
        bus.src_addr_b = 7'd3;
        drive(1'b1, 7'd3, d_a, 1'b0);
        tick();
        check_eq("young_pend0", {127'd0, bus.fwd_pending_b}, 128'd1);
        drive(1'b1, 7'd3, d_b, 1'b0);
        tick();
        idle();
        check_eq("young_pend1", {127'd0, bus.fwd_pending_b}, 128'd1);
        check_eq("young_nohit1", {127'd0, bus.fwd_hit_b}, 128'd0);
        check_eq("young_zero1", bus.fwd_data_b, 128'd0);
        tick();
        check_eq("young_hit2", {127'd0, bus.fwd_hit_b}, 128'd1);
        check_eq("young_data2", bus.fwd_data_b, d_b);
        repeat (8) tick();

        // Flush kills the three youngest in-flight issues
        bus.src_addr_c = 7'd13;
        for (int i = 0; i < 5; i++) begin
            dv[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
            drive(1'b1, 7'(10 + i), dv[i], i == 4);
            tick();
            if (i == 3) check_eq("flush_pre_pend_c", {127'd0, bus.fwd_pending_c}, 128'd1);
        end
        idle();
        check_eq("flush_c_gone", {126'd0, bus.fwd_hit_c, bus.fwd_pending_c}, 128'd0);
        repeat (9) tick();

        // Reset mid-flight discards everything immediately
        bus.src_addr_a = 7'd20;
        drive(1'b1, 7'd20, 128'h1, 1'b0); tick();
        drive(1'b1, 7'd21, 128'h2, 1'b0); tick();
        drive(1'b1, 7'd22, 128'h3, 1'b0); tick();
        idle();
        check_eq("mid_hit_a", {127'd0, bus.fwd_hit_a}, 128'd1);
        #2;
        rst_n = 1'b0;
        sbq.delete();
        #1;
        check_eq("mid_rst_hit_a", {127'd0, bus.fwd_hit_a}, 128'd0);
        check_eq("mid_rst_data_a", bus.fwd_data_a, 128'd0);
        check_eq("mid_rst_wb", {127'd0, bus.wb_valid}, 128'd0);
        tick();
        rst_n = 1'b1;
        repeat (10) tick();

        // Shallow build: forwardable straight from capture, retires after 4 cycles
        bus2.src_addr_a = 7'd77;
        bus2.in_valid   = 1'b1;
        bus2.in_rt_addr = 7'd77;
        bus2.in_result  = d9;
        tick();
        bus2.in_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            check_eq("sh_hit", {127'd0, bus2.fwd_hit_a}, 128'd1);
            check_eq("sh_pend", {127'd0, bus2.fwd_pending_a}, 128'd0);
            check_eq("sh_data", bus2.fwd_data_a, d9);
            check_eq("sh_wb_valid", {127'd0, bus2.wb_valid}, {127'd0, i == 4});
            if (i == 4) begin
                check_eq("sh_wb_rt", {121'd0, bus2.wb_rt_addr}, 128'd77);
                check_eq("sh_wb_data", bus2.wb_data, d9);
            end
            tick();
        end
        check_eq("sh_wb_done", {127'd0, bus2.wb_valid}, 128'd0);
        check_eq("sh_gone", {126'd0, bus2.fwd_hit_a, bus2.fwd_pending_a}, 128'd0);

        tick();
        check_eq("sb_empty", 128'(sbq.size()), 128'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
